// File: rtl/exhaustive_vector_sequencer_if.sv
// Record channel from the vector sequencer to a downstream logger.
// Valid/ready handshake carrying one {vector index, response bit} record per transfer.
interface exhaustive_vector_sequencer_if #(
  parameter int WIDTH = 6
) ();
  logic             rec_valid;
  logic             rec_ready;
  logic [WIDTH-1:0] rec_vec;
  logic             rec_bit;

  modport master (
    output rec_valid,
    output rec_vec,
    output rec_bit,
    input  rec_ready
  );

  modport slave (
    input  rec_valid,
    input  rec_vec,
    input  rec_bit,
    output rec_ready
  );
endinterface

// File: rtl/exhaustive_vector_sequencer.sv
// Walks every input vector of a WIDTH-input combinational DUT, samples its response after a
// settle delay, logs each {index, bit} record and accumulates a response map and a ones count.
module exhaustive_vector_sequencer #(
  parameter int WIDTH  = 6,
  parameter int SETTLE = 1
) (
  input  logic                    CK,
  input  logic                    reset,
  input  logic                    start,
  output logic [0:WIDTH-1]        N,
  input  logic                    dut_out,
  output logic                    busy,
  output logic                    done,
  exhaustive_vector_sequencer_if.master rec,
  output logic [(1<<WIDTH)-1:0]   resp_map,
  output logic [WIDTH:0]          ones_count
);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE_ST,
    SAMPLE,
    EMIT,
    DONE
  } state_t;

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [WIDTH-1:0] LAST_IDX    = {WIDTH{1'b1}};

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       idx_q, idx_d;
  logic [3:0]             settle_cnt_q, settle_cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   rec_valid_q, rec_valid_d;
  logic [WIDTH-1:0]       rec_vec_q, rec_vec_d;
  logic                   rec_bit_q, rec_bit_d;
  logic [(1<<WIDTH)-1:0]  resp_map_q, resp_map_d;
  logic [WIDTH:0]         ones_count_q, ones_count_d;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    settle_cnt_d = settle_cnt_q;
    rec_valid_d  = rec_valid_q;
    rec_vec_d    = rec_vec_q;
    rec_bit_d    = rec_bit_q;
    resp_map_d   = resp_map_q;
    ones_count_d = ones_count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d        = '0;
          settle_cnt_d = '0;
          resp_map_d   = '0;
          ones_count_d = '0;
          state_d      = SETTLE_ST;
        end
      end
      SETTLE_ST: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          settle_cnt_d = '0;
          state_d      = SAMPLE;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      SAMPLE: begin
        resp_map_d[idx_q] = dut_out;
        rec_bit_d         = dut_out;
        rec_vec_d         = idx_q;
        rec_valid_d       = 1'b1;
        if (dut_out) begin
          ones_count_d = ones_count_q + (WIDTH+1)'(1);
        end
        state_d = EMIT;
      end
      EMIT: begin
        // The last vector is all ones; stop there rather than letting the index wrap.
        if (rec.rec_ready) begin
          rec_valid_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + WIDTH'(1);
            state_d = SETTLE_ST;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status outputs are decoded from the next state so they come straight off flops.
    busy_d = (state_d == SETTLE_ST) || (state_d == SAMPLE) || (state_d == EMIT);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      settle_cnt_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rec_valid_q  <= 1'b0;
      rec_vec_q    <= '0;
      rec_bit_q    <= 1'b0;
      resp_map_q   <= '0;
      ones_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      settle_cnt_q <= settle_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rec_valid_q  <= rec_valid_d;
      rec_vec_q    <= rec_vec_d;
      rec_bit_q    <= rec_bit_d;
      resp_map_q   <= resp_map_d;
      ones_count_q <= ones_count_d;
    end
  end

  assign N             = idx_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign rec.rec_valid = rec_valid_q;
  assign rec.rec_vec   = rec_vec_q;
  assign rec.rec_bit   = rec_bit_q;
  assign resp_map      = resp_map_q;
  assign ones_count    = ones_count_q;

endmodule

// File: tb/tb_exhaustive_vector_sequencer.sv
// Table-driven bench for exhaustive_vector_sequencer: full sweeps against small reference DUTs,
// plus hand-written stall, mid-sweep reset and ignored-start sequences.
module tb_exhaustive_vector_sequencer;

  localparam int WIDTH = 6;
  localparam int NVEC  = 1 << WIDTH;

  localparam int M_XOR  = 0;
  localparam int M_AND  = 1;
  localparam int M_OR   = 2;
  localparam int M_ZERO = 3;
  localparam int M_MSB  = 4;
  localparam int M_LSB  = 5;

  typedef struct {
    int          mode;
    bit          sel;
    logic [63:0] expMap;
    int          expOnes;
    int          expDoneEdge;
    bit          expLastBit;
    int          stallVec;
  } vec_t;

  logic CK = 1'b0;
  logic reset;
  logic start;
  logic ready;
  bit   sel;
  int   mode;

  int checks = 0;
  int errors = 0;

  logic             start1, start3;
  logic [0:WIDTH-1] n1, n3;
  logic             dout1, dout3;
  logic             busy1, busy3, done1, done3;
  logic [63:0]      map1, map3;
  logic [WIDTH:0]   ones1, ones3;

  logic [WIDTH-1:0] obs_N, obs_vec;
  logic             obs_busy, obs_done, obs_valid, obs_bit;
  logic [63:0]      obs_map;
  logic [WIDTH:0]   obs_ones;

  exhaustive_vector_sequencer_if #(.WIDTH(WIDTH)) rif1 ();
  exhaustive_vector_sequencer_if #(.WIDTH(WIDTH)) rif3 ();

  always #5 CK = ~CK;

  // Reference DUT stubs; N[0] is the MSB of the applied vector.
  function automatic logic dutModel(input int m, input logic [0:WIDTH-1] v);
    case (m)
      M_XOR:   return ^v;
      M_AND:   return &v;
      M_OR:    return |v;
      M_MSB:   return v[0];
      M_LSB:   return v[WIDTH-1];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic expBit(input int m, input logic [WIDTH-1:0] idx);
    case (m)
      M_XOR:   return ^idx;
      M_AND:   return &idx;
      M_OR:    return |idx;
      M_MSB:   return idx[WIDTH-1];
      M_LSB:   return idx[0];
      default: return 1'b0;
    endcase
  endfunction

  assign dout1  = dutModel(mode, n1);
  assign dout3  = dutModel(mode, n3);
  assign start1 = start & ~sel;
  assign start3 = start & sel;
  assign rif1.rec_ready = ready;
  assign rif3.rec_ready = ready;

  exhaustive_vector_sequencer #(.WIDTH(WIDTH), .SETTLE(1)) dut1 (
    .CK(CK), .reset(reset), .start(start1), .N(n1), .dut_out(dout1),
    .busy(busy1), .done(done1), .rec(rif1.master),
    .resp_map(map1), .ones_count(ones1)
  );

  exhaustive_vector_sequencer #(.WIDTH(WIDTH), .SETTLE(3)) dut3 (
    .CK(CK), .reset(reset), .start(start3), .N(n3), .dut_out(dout3),
    .busy(busy3), .done(done3), .rec(rif3.master),
    .resp_map(map3), .ones_count(ones3)
  );

  assign obs_N     = sel ? n3 : n1;
  assign obs_busy  = sel ? busy3 : busy1;
  assign obs_done  = sel ? done3 : done1;
  assign obs_valid = sel ? rif3.rec_valid : rif1.rec_valid;
  assign obs_vec   = sel ? rif3.rec_vec : rif1.rec_vec;
  assign obs_bit   = sel ? rif3.rec_bit : rif1.rec_bit;
  assign obs_map   = sel ? map3 : map1;
  assign obs_ones  = sel ? ones3 : ones1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".N"},         64'(obs_N), 64'd0);
    checkOutput({tag, ".busy"},      64'(obs_busy), 64'd0);
    checkOutput({tag, ".done"},      64'(obs_done), 64'd0);
    checkOutput({tag, ".rec_valid"}, 64'(obs_valid), 64'd0);
    checkOutput({tag, ".rec_vec"},   64'(obs_vec), 64'd0);
    checkOutput({tag, ".rec_bit"},   64'(obs_bit), 64'd0);
    checkOutput({tag, ".resp_map"},  obs_map, 64'd0);
    checkOutput({tag, ".ones"},      64'(obs_ones), 64'd0);
  endtask

  // One sweep: start pulse, per-cycle record checking, optional stall, start pokes or abort.
  task automatic applyStimulus(input vec_t v, input int abortIdx, input bit pokeStart,
                               output bit aborted);
    int k, limit, recCount, doneSeen, doneEdge, stallLeft, lastVec;
    bit stalled, lastBit;
    sel = v.sel;
    mode = v.mode;
    ready = 1'b1;
    recCount = 0; doneSeen = 0; doneEdge = -1; stallLeft = 0; stalled = 0;
    lastVec = -1; lastBit = 1'b0; aborted = 1'b0;
    @(posedge CK); #1;
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    k = 0;
    limit = v.expDoneEdge + 40;
    while (k < limit && !(doneSeen > 0 && k >= doneEdge + 3)) begin
      @(posedge CK); #1;
      k++;
      start = 1'b0;
      if (obs_done) begin
        doneSeen++;
        if (doneEdge < 0) begin
          doneEdge = k;
          if (pokeStart) start = 1'b1;
        end
      end
      if (pokeStart && (k == 50 || k == 100)) start = 1'b1;
      if (abortIdx >= 0 && obs_busy && int'(obs_N) == abortIdx) begin
        reset = 1'b0;
        #1;
        checkAllZero("abort");
        checkOutput("abort.noDone", 64'(doneSeen), 64'd0);
        aborted = 1'b1;
        break;
      end
      if (stallLeft > 0) begin
        stallLeft--;
        if (stallLeft == 0) ready = 1'b1;
      end else if (!stalled && obs_valid && int'(obs_vec) == v.stallVec) begin
        ready = 1'b0;
        stallLeft = 5;
        stalled = 1'b1;
      end
      if (!ready) begin
        checkOutput("stall.valid", 64'(obs_valid), 64'd1);
        checkOutput("stall.vec",   64'(obs_vec), 64'(v.stallVec));
        checkOutput("stall.N",     64'(obs_N), 64'(v.stallVec));
      end else if (obs_valid) begin
        checkOutput("rec.vec", 64'(obs_vec), 64'(recCount));
        checkOutput("rec.bit", 64'(obs_bit), 64'(expBit(v.mode, WIDTH'(recCount))));
        checkOutput("rec.N",   64'(obs_N), 64'(recCount));
        lastVec = int'(obs_vec);
        lastBit = obs_bit;
        recCount++;
      end
    end
    if (!aborted) begin
      checkOutput("doneCount",   64'(doneSeen), 64'd1);
      checkOutput("doneEdge",    64'(doneEdge), 64'(v.expDoneEdge));
      checkOutput("recCount",    64'(recCount), 64'(NVEC));
      checkOutput("lastVec",     64'(lastVec), 64'(NVEC - 1));
      checkOutput("lastBit",     64'(lastBit), 64'(v.expLastBit));
      checkOutput("idle.busy",   64'(obs_busy), 64'd0);
      checkOutput("idle.done",   64'(obs_done), 64'd0);
      checkOutput("idle.valid",  64'(obs_valid), 64'd0);
      checkOutput("resp_map",    obs_map, v.expMap);
      checkOutput("ones_count",  64'(obs_ones), 64'(v.expOnes));
      checkOutput("idle.N",      64'(obs_N), 64'(NVEC - 1));
    end
  endtask

  initial begin
    vec_t tbl[7];
    bit   ab;

    tbl[0] = '{M_XOR,  1'b0, 64'h6996966996696996, 32, 192, 1'b0, -1};
    tbl[1] = '{M_AND,  1'b0, 64'h8000000000000000,  1, 192, 1'b1, -1};
    tbl[2] = '{M_OR,   1'b0, 64'hFFFFFFFFFFFFFFFE, 63, 192, 1'b1, -1};
    tbl[3] = '{M_ZERO, 1'b0, 64'h0000000000000000,  0, 192, 1'b0, -1};
    tbl[4] = '{M_MSB,  1'b0, 64'hFFFFFFFF00000000, 32, 192, 1'b1, -1};
    tbl[5] = '{M_LSB,  1'b0, 64'hAAAAAAAAAAAAAAAA, 32, 192, 1'b1, -1};
    tbl[6] = '{M_XOR,  1'b1, 64'h6996966996696996, 32, 320, 1'b0, -1};

    reset = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    sel   = 1'b0;
    mode  = M_XOR;
    #3;
    checkAllZero("reset1");
    sel = 1'b1;
    #1;
    checkAllZero("reset3");
    sel = 1'b0;
    @(posedge CK); #1;
    @(posedge CK); #1;
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      $display("[TB] sweep entry %0d", i);
      applyStimulus(tbl[i], -1, 1'b0, ab);
    end

    $display("[TB] stall at vector 10");
    begin
      vec_t s;
      s = tbl[0];
      s.stallVec = 10;
      s.expDoneEdge = 197;
      applyStimulus(s, -1, 1'b0, ab);
    end

    $display("[TB] reset pulse at idx 20");
    applyStimulus(tbl[0], 20, 1'b0, ab);
    checkOutput("abort.hit", 64'(ab), 64'd1);
    @(posedge CK); #1;
    @(posedge CK); #1;
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge CK); #1;
      checkOutput("postAbort.done", 64'(obs_done), 64'd0);
      checkOutput("postAbort.busy", 64'(obs_busy), 64'd0);
    end
    applyStimulus(tbl[0], -1, 1'b0, ab);

    $display("[TB] start re-asserted while busy and in DONE");
    applyStimulus(tbl[1], -1, 1'b1, ab);
    for (int i = 0; i < 4; i++) begin
      @(posedge CK); #1;
      checkOutput("ignoredStart.busy", 64'(obs_busy), 64'd0);
      checkOutput("ignoredStart.done", 64'(obs_done), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
